// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control units: state encoding, opcode/funct
// constants, ALU codes, datapath mux encodings and the per-state output decode.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // fetch/jump/branch are internal qualifiers combined with mem_ready and zero
  // at the output; everything else goes straight to the datapath.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem2reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       fetch;
    logic       jump;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_t s, input logic is_jr,
                                        input logic [2:0] exec_op);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    c.pc_src = PCSRC_ALU;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.fetch     = 1'b1;
      end
      S_DECODE:  c.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write = 1'b1;
        c.mem2reg   = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = exec_op;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dest  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.branch    = 1'b1;
        c.pc_src    = PCSRC_ALUOUT;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_IWB:     c.reg_write = 1'b1;
      S_JUMP: begin
        c.jump   = 1'b1;
        c.pc_src = is_jr ? PCSRC_RS : PCSRC_JUMP;
      end
      default: c.alu_op = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct to ALU operation lookup; legal is low for functs with no ALU op.
module alu_funct_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: alu_op = ALU_ADD;
      FN_SUB, FN_SUBU: alu_op = ALU_SUB;
      FN_AND:          alu_op = ALU_AND;
      FN_OR:           alu_op = ALU_OR;
      FN_SLT, FN_SLTU: alu_op = ALU_SLT;
      default:         legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control: sequences fetch/decode/execute/memory/writeback and
// drives the shared datapath; outputs are registered from the next state.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem2reg,
  output logic               reg_dest,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  logic [2:0] dec_alu_op;
  logic       dec_legal;

  alu_funct_decoder u_funct_dec (
    .funct  (funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  state_t state_q, state_d;
  ctrl_t  ctrl_q,  ctrl_d;
  logic   illegal_q, illegal_d;
  logic   is_jr;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    is_jr     = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:      state_d = S_MEMADR;
          OP_BEQ:            state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU: state_d = S_IEXEC;
          OP_J: begin
            if (ENABLE_JUMP) state_d   = S_JUMP;
            else             illegal_d = 1'b1;
          end
          OP_RTYPE: begin
            if (ENABLE_JUMP && funct == FN_JR) begin
              state_d = S_JUMP;
              is_jr   = 1'b1;
            end else if (dec_legal) begin
              state_d = S_EXECUTE;
            end else begin
              illegal_d = 1'b1;
            end
          end
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_IEXEC:   state_d = S_IWB;
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_decode(state_d, is_jr, dec_alu_op);
  end

  // NOTE: the output register resets asynchronously to the FETCH decode, so an
  // interrupted store drops mem_write the moment rst_n falls, not at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_decode(S_FETCH, 1'b0, ALU_ADD);
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so state, outputs and flag all update from pre-edge values.
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  // Only the fetch handshake and the branch decision see live inputs.
  assign ir_write   = ctrl_q.fetch & mem_ready;
  assign pc_en      = (ctrl_q.fetch & mem_ready) | ctrl_q.jump | (ctrl_q.branch & zero);
  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign mem2reg    = ctrl_q.mem2reg;
  assign reg_dest   = ctrl_q.reg_dest;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ALUOP_W'(ctrl_q.alu_op);
  assign pc_src     = ctrl_q.pc_src;
  assign illegal_op = illegal_q;
  assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each cycle's expected outputs are pushed when inputs are
// driven and popped/compared on the falling edge.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_en, ir_write, i_or_d, mem_read, mem_write, mem2reg;
  logic       reg_dest, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  logic       nj_pc_en, nj_ir_write, nj_i_or_d, nj_mem_read, nj_mem_write, nj_mem2reg;
  logic       nj_reg_dest, nj_reg_write, nj_alu_src_a, nj_illegal_op;
  logic [1:0] nj_alu_src_b, nj_pc_src;
  logic [2:0] nj_alu_op;
  logic [3:0] nj_state_dbg;

  multicycle_control_fsm #(.ALUOP_W(3), .ENABLE_JUMP(1'b1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
    .reg_dest(reg_dest), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  multicycle_control_fsm #(.ALUOP_W(3), .ENABLE_JUMP(1'b0), .STATE_W(4)) dut_nj (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(nj_pc_en), .ir_write(nj_ir_write), .i_or_d(nj_i_or_d),
    .mem_read(nj_mem_read), .mem_write(nj_mem_write), .mem2reg(nj_mem2reg),
    .reg_dest(nj_reg_dest), .reg_write(nj_reg_write), .alu_src_a(nj_alu_src_a),
    .alu_src_b(nj_alu_src_b), .alu_op(nj_alu_op), .pc_src(nj_pc_src),
    .illegal_op(nj_illegal_op), .state_dbg(nj_state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_illegal = 1'b0;

  function automatic logic [2:0] tb_exec_op(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 3'b010;
      6'h22, 6'h23: return 3'b110;
      6'h24:        return 3'b000;
      6'h25:        return 3'b001;
      6'h2A, 6'h2B: return 3'b111;
      default:      return 3'b010;
    endcase
  endfunction

  function automatic logic tb_legal(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'h23, 6'h2B, 6'h04, 6'h08, 6'h09, 6'h02: return 1'b1;
      6'h00: return (f inside {6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B});
      default: return 1'b0;
    endcase
  endfunction

  // {state, mem_read, mem_write, i_or_d, mem2reg, reg_dest, reg_write,
  //  alu_src_a, alu_src_b, alu_op, pc_src, ir_write, pc_en, illegal_op}
  function automatic logic [20:0] model_out(input state_t st, input logic mr, input logic z);
    logic       m_rd, m_wr, iod, m2r, rdst, rw, asa, irw, pce;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    {m_rd, m_wr, iod, m2r, rdst, rw, asa, irw, pce} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b010;
    case (st)
      S_FETCH:   begin m_rd = 1'b1; asb = 2'b01; irw = mr; pce = mr; end
      S_DECODE:  asb = 2'b11;
      S_MEMADR:  begin asa = 1'b1; asb = 2'b10; end
      S_MEMRD:   begin m_rd = 1'b1; iod = 1'b1; end
      S_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:   begin m_wr = 1'b1; iod = 1'b1; end
      S_EXECUTE: begin asa = 1'b1; aop = tb_exec_op(funct); end
      S_ALUWB:   begin rw = 1'b1; rdst = 1'b1; end
      S_BRANCH:  begin asa = 1'b1; aop = 3'b110; psrc = 2'b01; pce = z; end
      S_IEXEC:   begin asa = 1'b1; asb = 2'b10; end
      S_IWB:     rw = 1'b1;
      S_JUMP:    begin pce = 1'b1; psrc = (opcode == 6'h00) ? 2'b11 : 2'b10; end
      default:   aop = 3'b010;
    endcase
    return {st, m_rd, m_wr, iod, m2r, rdst, rw, asa, asb, aop, psrc, irw, pce, exp_illegal};
  endfunction

  function automatic logic [20:0] observed();
    return {state_dbg, mem_read, mem_write, i_or_d, mem2reg, reg_dest, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_src, ir_write, pc_en, illegal_op};
  endfunction

  // One clock: drive inputs, queue expectation, compare at negedge, advance.
  task automatic cyc(input state_t st, input logic mr, input logic z, input string tag);
    exp_t e;
    mem_ready = mr;
    zero      = z;
    e.tag = tag;
    e.v   = model_out(st, mr, z);
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (observed() !== e.v)
      $display("FAIL %s (%s): got %h expected %h", e.tag, st.name(), observed(), e.v);
    else n_pass++;
    n_checks++;
    if ((mem_read & mem_write) !== 1'b0)
      $display("FAIL %s mem_excl: got rd=%b wr=%b expected not both 1", tag, mem_read, mem_write);
    else n_pass++;
    if (st == S_DECODE && !tb_legal(opcode, funct)) exp_illegal = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_illegal = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_lw(input string tag);
    opcode = 6'h23;
    cyc(S_FETCH, 1'b1, 1'b0, tag);
    cyc(S_DECODE, 1'b1, 1'b0, tag);
    cyc(S_MEMADR, 1'b1, 1'b0, tag);
    cyc(S_MEMRD, 1'b1, 1'b0, tag);
    cyc(S_MEMWB, 1'b1, 1'b0, tag);
  endtask

  task automatic run_rtype(input logic [5:0] f, input string tag);
    opcode = 6'h00;
    funct  = f;
    cyc(S_FETCH, 1'b1, 1'b0, tag);
    cyc(S_DECODE, 1'b1, 1'b0, tag);
    cyc(S_EXECUTE, 1'b1, 1'b0, tag);
    cyc(S_ALUWB, 1'b1, 1'b0, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(S_FETCH, 1'b0, 1'b0, "reset_hold");
    rst_n = 1'b1;
    cyc(S_FETCH, 1'b0, 1'b0, "fetch_wait");
  endtask

  task automatic test_lw();
    run_lw("lw");
  endtask

  task automatic test_sw_wait();
    opcode = 6'h2B;
    cyc(S_FETCH, 1'b0, 1'b0, "sw_fetch_wait");
    cyc(S_FETCH, 1'b1, 1'b0, "sw");
    cyc(S_DECODE, 1'b1, 1'b0, "sw");
    cyc(S_MEMADR, 1'b1, 1'b0, "sw");
    for (int i = 0; i < 3; i++) cyc(S_MEMWR, 1'b0, 1'b0, "sw_wr_wait");
    cyc(S_MEMWR, 1'b1, 1'b0, "sw_wr_done");
    cyc(S_FETCH, 1'b0, 1'b0, "sw_return");
  endtask

  task automatic test_rtype();
    logic [5:0] fl [6];
    fl = '{6'h22, 6'h2A, 6'h20, 6'h24, 6'h25, 6'h2B};
    foreach (fl[i]) run_rtype(fl[i], $sformatf("rtype_%h", fl[i]));
  endtask

  task automatic test_beq();
    opcode = 6'h04;
    cyc(S_FETCH, 1'b1, 1'b1, "beq_taken");
    cyc(S_DECODE, 1'b1, 1'b1, "beq_taken");
    cyc(S_BRANCH, 1'b1, 1'b1, "beq_taken");
    cyc(S_FETCH, 1'b1, 1'b0, "beq_nt");
    cyc(S_DECODE, 1'b1, 1'b0, "beq_nt");
    cyc(S_BRANCH, 1'b1, 1'b0, "beq_nt");
  endtask

  task automatic test_addi();
    opcode = 6'h09;
    cyc(S_FETCH, 1'b1, 1'b0, "addiu");
    cyc(S_DECODE, 1'b1, 1'b0, "addiu");
    cyc(S_IEXEC, 1'b1, 1'b0, "addiu");
    cyc(S_IWB, 1'b1, 1'b0, "addiu");
  endtask

  task automatic test_jump();
    do_reset();
    opcode = 6'h02;
    cyc(S_FETCH, 1'b1, 1'b0, "j");
    n_checks++;
    if (nj_illegal_op !== 1'b0)
      $display("FAIL nj_pre_decode illegal: got %b expected 0", nj_illegal_op);
    else n_pass++;
    cyc(S_DECODE, 1'b1, 1'b0, "j");
    n_checks++;
    if ({nj_state_dbg, nj_illegal_op} !== {S_FETCH, 1'b1})
      $display("FAIL nj_j_illegal: got state=%0d ill=%b expected state=0 ill=1",
               nj_state_dbg, nj_illegal_op);
    else n_pass++;
    cyc(S_JUMP, 1'b1, 1'b0, "j");
    opcode = 6'h00;
    funct  = 6'h08;
    cyc(S_FETCH, 1'b1, 1'b0, "jr");
    cyc(S_DECODE, 1'b1, 1'b0, "jr");
    cyc(S_JUMP, 1'b1, 1'b0, "jr");
    do_reset();
  endtask

  task automatic test_illegal();
    opcode = 6'h3F;
    cyc(S_FETCH, 1'b1, 1'b0, "ill_3f");
    cyc(S_DECODE, 1'b1, 1'b0, "ill_3f");
    run_lw("lw_after_ill");
    run_rtype(6'h22, "sub_after_ill");
    opcode = 6'h00;
    funct  = 6'h27;
    cyc(S_FETCH, 1'b1, 1'b0, "ill_funct27");
    cyc(S_DECODE, 1'b1, 1'b0, "ill_funct27");
    cyc(S_FETCH, 1'b0, 1'b0, "ill_sticky");
  endtask

  task automatic test_reset_mid_sw();
    opcode = 6'h2B;
    cyc(S_FETCH, 1'b1, 1'b0, "sw_rst");
    cyc(S_DECODE, 1'b1, 1'b0, "sw_rst");
    cyc(S_MEMADR, 1'b1, 1'b0, "sw_rst");
    cyc(S_MEMWR, 1'b0, 1'b0, "sw_rst");
    n_checks++;
    if ({state_dbg, mem_write, illegal_op} !== {S_MEMWR, 1'b1, 1'b1})
      $display("FAIL pre_reset: got state=%0d wr=%b ill=%b expected state=5 wr=1 ill=1",
               state_dbg, mem_write, illegal_op);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    exp_illegal = 1'b0;
    n_checks++;
    if (observed() !== model_out(S_FETCH, 1'b0, 1'b0))
      $display("FAIL reset_mid_sw: got %h expected %h", observed(), model_out(S_FETCH, 1'b0, 1'b0));
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_lw("lw_after_reset");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_beq();
    test_addi();
    test_jump();
    test_illegal();
    test_reset_mid_sw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
